// File: rtl/fetch_pkg.sv
// Shared constants, queue entry type and decode helper for the instruction
// fetch queue.
package fetch_pkg;

  localparam logic [15:0] NOP_INST = 16'h0800;
  localparam logic [4:0]  HALT_OPC = 5'b00000;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } fq_entry_t;

  function automatic logic is_halt(input logic [15:0] inst);
    return (inst[15:11] == HALT_OPC);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction memory request/response bus; the fetch queue is the master.
interface fetch_queue_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {inst, pc} entries with occupancy count and a
// single-cycle flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fq_entry_t                i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fq_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  fq_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign w_full = (r_count == FULL_CNT);
  assign w_push = i_push && !w_full;
  assign w_pop  = i_pop && (r_count != {CNT_W{1'b0}});

  // Pointers and occupancy; flush empties the queue in one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (i_flush) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{inst: NOP_INST, pc: 16'h0000};
      end
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential imem requests, buffers the
// returned words and presents the head entry to the IF/ID register.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  input  logic          stall,
  fetch_queue_if.master imem,
  output logic [15:0]   instruction,
  output logic [15:0]   pc_out,
  output logic [15:0]   pc_next,
  output logic          inst_valid,
  output logic          halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [15:0]      r_fetch_pc;
  logic             r_halted;
  logic             w_req;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  logic [15:0]      w_redirect_pc;
  fq_entry_t        w_head;
  fq_entry_t        w_wdata;

  // rst gates the request so it drops the instant reset asserts
  assign w_req         = rst && !r_halted && !w_full;
  assign w_push        = w_req && imem.imem_ready && !redirect;
  assign w_valid       = (w_count != {CNT_W{1'b0}}) && !redirect;
  assign w_pop         = w_valid && !stall;
  assign w_redirect_pc = redirect_pc & 16'hFFFE;
  assign w_wdata       = '{inst: imem.imem_data, pc: r_fetch_pc};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // Fetch address and halt flag; redirect wins over any same-cycle push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_halted   <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_halted   <= 1'b0;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 16'd2;
      r_halted   <= r_halted || is_halt(imem.imem_data);
    end else begin
      r_fetch_pc <= r_fetch_pc;
      r_halted   <= r_halted;
    end
  end

  // Head presentation: NOP at the current fetch address when nothing is valid
  always_comb begin
    instruction = NOP_INST;
    pc_out      = r_fetch_pc;
    if (w_valid) begin
      instruction = w_head.inst;
      pc_out      = w_head.pc;
    end else begin
      instruction = NOP_INST;
      pc_out      = r_fetch_pc;
    end
    pc_next = pc_out + 16'd2;
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;
  assign inst_valid     = w_valid;
  assign halted         = r_halted;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue against a queue-based
// transaction model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic [15:0] instruction, pc_out, pc_next;
  logic        inst_valid, halted;

  logic        rst2;
  logic [15:0] instruction2, pc_out2, pc_next2;
  logic        inst_valid2, halted2;

  fetch_queue_if imem ();
  fetch_queue_if imem2 ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem(imem), .instruction(instruction), .pc_out(pc_out),
    .pc_next(pc_next), .inst_valid(inst_valid), .halted(halted)
  );

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .redirect(1'b0), .redirect_pc(16'h0000),
    .stall(1'b0), .imem(imem2), .instruction(instruction2), .pc_out(pc_out2),
    .pc_next(pc_next2), .inst_valid(inst_valid2), .halted(halted2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {1'b1, a[14:0] ^ 15'h2A5B};
  endfunction

  assign imem2.imem_ready = 1'b1;
  assign imem2.imem_data  = mem_word(imem2.imem_addr);

  // reference model state
  fq_entry_t   m_q[$];
  logic [15:0] m_pc;
  logic        m_halted;
  logic        m_rst_n;
  logic        c_rdy, c_stl, c_rd;
  logic [15:0] c_data;
  logic [15:0] c_rpc;
  logic        e_req, e_valid, e_halted;
  logic [15:0] e_addr, e_inst, e_pc, e_pcn;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [65:0] obs();
    return {imem.imem_req, imem.imem_addr, inst_valid, instruction, pc_out, pc_next, halted};
  endfunction

  function automatic logic [65:0] expv();
    return {e_req, e_addr, e_valid, e_inst, e_pc, e_pcn, e_halted};
  endfunction

  task automatic apply(input logic rdy, input logic stl, input logic rd,
                       input logic [15:0] rpc, input logic force_halt);
    @(negedge clk);
    c_rdy  = rdy;
    c_stl  = stl;
    c_rd   = rd;
    c_rpc  = rpc;
    c_data = force_halt ? 16'h0000 : mem_word(m_pc);
    imem.imem_ready = rdy;
    imem.imem_data  = c_data;
    stall       = stl;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    e_req    = m_rst_n && !m_halted && (m_q.size() < DEPTH);
    e_addr   = m_pc;
    e_valid  = (m_q.size() != 0) && !c_rd;
    e_inst   = e_valid ? m_q[0].inst : 16'h0800;
    e_pc     = e_valid ? m_q[0].pc : m_pc;
    e_pcn    = e_pc + 16'd2;
    e_halted = m_halted;
  endtask

  task automatic commit();
    @(posedge clk);
    if (!m_rst_n) begin
      m_q.delete();
    end else if (c_rd) begin
      m_q.delete();
      m_pc     = {c_rpc[15:1], 1'b0};
      m_halted = 1'b0;
    end else begin
      if (e_valid && !c_stl) void'(m_q.pop_front());
      if (e_req && c_rdy) begin
        m_q.push_back('{inst: c_data, pc: m_pc});
        if (c_data[15:11] == 5'b00000) m_halted = 1'b1;
        m_pc = m_pc + 16'd2;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rst2 = 1'b0;
    m_q.delete(); m_pc = 16'h0000; m_halted = 1'b0; m_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (obs() !== expv()) $display("FAIL reset_model: got %h expected %h", obs(), expv());
    else n_pass++;
    n_checks++;
    if ({imem.imem_req, inst_valid, halted} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {imem.imem_req, inst_valid, halted});
    else n_pass++;
    n_checks++;
    if ({instruction, pc_out, pc_next} !== {16'h0800, 16'h0000, 16'h0002})
      $display("FAIL reset_outs: got %h expected 0800_0000_0002", {instruction, pc_out, pc_next});
    else n_pass++;
    n_checks++;
    if ({imem2.imem_req, pc_out2, pc_next2} !== {1'b0, 16'hFFFC, 16'hFFFE})
      $display("FAIL reset_wrap: got %h expected 0_fffc_fffe", {imem2.imem_req, pc_out2, pc_next2});
    else n_pass++;
    commit();
  endtask

  task automatic test_sequential();
    #2 rst = 1'b1; m_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL seq_model[%0d]: got %h expected %h", k, obs(), expv());
      else n_pass++;
      n_checks++;
      if ({imem.imem_req, imem.imem_addr} !== {1'b1, 16'(2 * k)})
        $display("FAIL seq_addr[%0d]: got %h expected %h", k, imem.imem_addr, 16'(2 * k));
      else n_pass++;
      if (k == 0) begin
        n_checks++;
        if (inst_valid !== 1'b0) $display("FAIL seq_first_valid: got %b expected 0", inst_valid);
        else n_pass++;
      end
      if (k == 1) begin
        n_checks++;
        if ({inst_valid, pc_out, pc_next} !== {1'b1, 16'h0000, 16'h0002})
          $display("FAIL seq_head: got %h expected 1_0000_0002", {inst_valid, pc_out, pc_next});
        else n_pass++;
      end
      commit();
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_pc;
    apply(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0);
    commit();
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL stall_model[%0d]: got %h expected %h", k, obs(), expv());
      else n_pass++;
      if (k >= 2) begin
        n_checks++;
        if ({imem.imem_req, inst_valid, pc_out} !== {1'b0, 1'b1, 16'h0100})
          $display("FAIL stall_hold[%0d]: got %h expected 0_1_0100", k, {imem.imem_req, inst_valid, pc_out});
        else n_pass++;
      end
      commit();
    end
    exp_pc = 16'h0100;
    for (int k = 0; k < 8; k++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL release_model[%0d]: got %h expected %h", k, obs(), expv());
      else n_pass++;
      n_checks++;
      if (inst_valid !== 1'b1 || pc_out !== exp_pc)
        $display("FAIL release_order[%0d]: got %b/%h expected 1/%h", k, inst_valid, pc_out, exp_pc);
      else n_pass++;
      exp_pc = exp_pc + 16'd2;
      commit();
    end
  endtask

  task automatic test_redirect();
    logic [15:0] dropped_pc;
    logic [15:0] exp_pc;
    dropped_pc = m_pc;
    apply(1'b1, 1'b0, 1'b1, 16'h0041, 1'b0);
    n_checks++;
    if (inst_valid !== 1'b0) $display("FAIL redir_mask: got %b expected 0", inst_valid);
    else n_pass++;
    commit();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if ({imem.imem_req, imem.imem_addr, inst_valid} !== {1'b1, 16'h0040, 1'b0})
      $display("FAIL redir_target: got %h expected 1_0040_0", {imem.imem_req, imem.imem_addr, inst_valid});
    else n_pass++;
    commit();
    exp_pc = 16'h0040;
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL redir_model[%0d]: got %h expected %h", k, obs(), expv());
      else n_pass++;
      if (inst_valid) begin
        n_checks++;
        if (pc_out !== exp_pc || pc_out === dropped_pc)
          $display("FAIL redir_stream[%0d]: got %h expected %h", k, pc_out, exp_pc);
        else n_pass++;
        exp_pc = exp_pc + 16'd2;
      end
      commit();
    end
  endtask

  task automatic test_halt();
    logic saw_halt;
    saw_halt = 1'b0;
    apply(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
    commit();
    for (int k = 0; k < 12; k++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0000, m_pc == 16'h0006);
      n_checks++;
      if (obs() !== expv()) $display("FAIL halt_model[%0d]: got %h expected %h", k, obs(), expv());
      else n_pass++;
      if (inst_valid && pc_out == 16'h0006 && instruction == 16'h0000) saw_halt = 1'b1;
      commit();
    end
    n_checks++;
    if ({saw_halt, halted, imem.imem_req} !== 3'b110)
      $display("FAIL halt_state: got %b expected 110", {saw_halt, halted, imem.imem_req});
    else n_pass++;
    apply(1'b1, 1'b0, 1'b1, 16'h0010, 1'b0);
    commit();
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if ({halted, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 16'h0010})
      $display("FAIL halt_resume: got %h expected 0_1_0010", {halted, imem.imem_req, imem.imem_addr});
    else n_pass++;
    commit();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 15) == 0), 16'($urandom), 1'($urandom_range(0, 24) == 0));
      n_checks++;
      if (obs() !== expv()) $display("FAIL rand_model[%0d]: got %h expected %h", k, obs(), expv());
      else n_pass++;
      commit();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'hFFFC; exp_seq[1] = 16'hFFFE; exp_seq[2] = 16'h0000;
    @(posedge clk);
    #2 rst2 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({inst_valid2, halted2, pc_out2, pc_next2} !== {1'b1, 1'b0, exp_seq[k], exp_seq[k] + 16'd2})
        $display("FAIL wrap[%0d]: got %b%b_%h_%h expected 10_%h_%h", k, inst_valid2, halted2,
                 pc_out2, pc_next2, exp_seq[k], exp_seq[k] + 16'd2);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    apply(1'b1, 1'b0, 1'b1, 16'h0200, 1'b0);
    commit();
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 16'h0200})
      $display("FAIL mid_pending: got %h expected 1_0200", {imem.imem_req, imem.imem_addr});
    else n_pass++;
    rst = 1'b0;
    m_q.delete(); m_pc = 16'h0000; m_halted = 1'b0; m_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem.imem_req, inst_valid, halted, instruction, pc_out, pc_next} !==
        {3'b000, 16'h0800, 16'h0000, 16'h0002})
      $display("FAIL mid_reset: got %h expected 0_0800_0000_0002",
               {imem.imem_req, inst_valid, halted, instruction, pc_out, pc_next});
    else n_pass++;
    commit();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (obs() !== expv()) $display("FAIL mid_late_ready: got %h expected %h", obs(), expv());
    else n_pass++;
    commit();
    #2 rst = 1'b1; m_rst_n = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if ({imem.imem_req, imem.imem_addr, inst_valid} !== {1'b1, 16'h0000, 1'b0})
      $display("FAIL mid_restart: got %h expected 1_0000_0", {imem.imem_req, imem.imem_addr, inst_valid});
    else n_pass++;
    commit();
  endtask

  initial begin
    redirect = 1'b0; redirect_pc = 16'h0000; stall = 1'b0;
    imem.imem_ready = 1'b0; imem.imem_data = 16'h0000;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
